mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch-stage requester (instruction reads) and the memory-stage requester (data loads and stores).
- Sits between the pipeline's fetch and memory stages and the memory model.
- Serialises accesses and drives per-stage stall signals so the pipeline registers hold while a stage waits.
- Gives data priority, with a starvation guard for fetch and a timeout error for a memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits
- TIMEOUT, 16, cycles allowed for mem_ack before error

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready
- d_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle access completion from memory
- stall_if  out  1  fetch stage must hold
- stall_mem  out  1  memory stage must hold
- err  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0, starve counter 0, timeout counter 0, state IDLE.
  - An in-flight access is abandoned; mem_en drops immediately, with no ready pulse.
- States: IDLE, ACC_I, ACC_D, RESP_I, RESP_D.
- IDLE, arbitration:
  - d_req=1 and (if_req=0 or starve<STARVE_MAX) → latch d_we/d_addr/d_wdata, go to ACC_D. If if_req=1 at the same time, starve increments (saturating at STARVE_MAX).
  - Otherwise if_req=1 → latch if_addr, go to ACC_I, starve←0.
  - Neither request → stay in IDLE.
- ACC_x:
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the latched registers (mem_we=0 in ACC_I).
  - Requester inputs are not re-sampled in this state.
  - Timeout counter increments each cycle.
- mem_ack in ACC_x:
  - Read: mem_rdata is captured into if_rdata or d_rdata.
  - Store: d_rdata is left unchanged.
  - Go to RESP_x; the timeout counter clears.
- RESP_x:
  - The matching ready=1 for exactly this cycle; mem_en=0.
  - Next state is always IDLE. A request still high in the next IDLE cycle counts as a new request, so requesters must drop or replace req after ready.
- Latency:
  - Grant cycle, then ≥1 ACC cycle, then RESP. Minimum 3 cycles from request to ready, with mem_ack on the first ACC cycle.
  - Back-to-back accesses cost one IDLE cycle between them.
- Timeout:
  - Timeout counter reaches TIMEOUT in ACC_x → err←1 (sticky until reset).
  - The access completes as a forced response: ready pulses with rdata=0, and the state goes through RESP_x.
- mem_ack seen in IDLE or RESP_x is ignored.
- Stalls (combinational):
  - stall_if = if_req & ~if_ready
  - stall_mem = d_req & ~d_ready
- if_rdata and d_rdata hold their last value outside the ready cycle.
- Starve counter: width clog2(STARVE_MAX+1); clears on every fetch grant; never wraps.

Test Plan:
- Single fetch, if_addr=0x10, mem_ack on the first ACC cycle with mem_rdata=0x8C010004 → mem_en high for 1 cycle with mem_addr=0x10; if_ready pulses at cycle 3 with if_rdata=0x8C010004; stall_if is high for cycles 1–2.
- if_req and d_req raised together (load, d_addr=0x20) → data served first; the fetch is granted in the IDLE cycle after d_ready; starve=0 after the fetch grant.
- Starvation: d_req held with a new request each time (5 loads) while if_req is held → after 4 data grants the 5th grant goes to fetch; the remaining load is served afterwards.
- Store, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ack delayed 3 cycles → mem_we=1, mem_wdata=0xDEADBEEF for 3 cycles; d_ready pulses once; d_rdata is unchanged.
- No mem_ack for 16 cycles → err=1, if_ready pulses with if_rdata=0, state returns to IDLE; err stays 1 through later successful accesses.
- rst_n pulled low in the middle of ACC_D → mem_en, stall outputs and ready outputs go to 0 immediately; after release, the state is IDLE and a fresh if_req completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory: data first,
// a starvation guard for fetch, and a sticky error when the memory never acknowledges.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [TMO_W-1:0]    TMO_LIM    = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACC_I  = 3'd1,
        S_ACC_D  = 3'd2,
        S_RESP_I = 3'd3,
        S_RESP_D = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [TMO_W-1:0]    tmo_inc_s;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                acc_s, if_ready_s, d_ready_s;

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state: arbitration in IDLE, ack/timeout handling in ACC, RESP always returns to IDLE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        tmo_inc_s  = tmo_q + TMO_W'(1);
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (bus.d_req && (!bus.if_req || (starve_q < STARVE_LIM))) begin
                    state_d = S_ACC_D;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    if (bus.if_req && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (bus.if_req) begin
                    state_d  = S_ACC_I;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    starve_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC_I, S_ACC_D: begin
                if (bus.mem_ack) begin
                    state_d = (state_q == S_ACC_I) ? S_RESP_I : S_RESP_D;
                    tmo_d   = '0;
                    if (state_q == S_ACC_I) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else if (tmo_inc_s == TMO_LIM) begin
                    // Forced response: the requester sees a zero read and moves on.
                    state_d = (state_q == S_ACC_I) ? S_RESP_I : S_RESP_D;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    if (state_q == S_ACC_I) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            S_RESP_I, S_RESP_D: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register; stalls gated by reset so they drop with it.
    always_comb begin
        acc_s         = (state_q == S_ACC_I) || (state_q == S_ACC_D);
        if_ready_s    = (state_q == S_RESP_I);
        d_ready_s     = (state_q == S_RESP_D);
        bus.mem_en    = acc_s;
        bus.mem_we    = (state_q == S_ACC_D) && we_q;
        bus.mem_addr  = acc_s ? addr_q : '0;
        bus.mem_wdata = (state_q == S_ACC_D) ? wdata_q : '0;
        bus.if_ready  = if_ready_s;
        bus.d_ready   = d_ready_s;
        bus.if_rdata  = if_rdata_q;
        bus.d_rdata   = d_rdata_q;
        bus.err       = err_q;
        bus.stall_if  = rst_n & bus.if_req & ~if_ready_s;
        bus.stall_mem = rst_n & bus.d_req & ~d_ready_s;
    end
endmodule
